sqrt_seq_controller: RTL
========================

# sqrt_seq_controller

Parametrised state-sequencing controller for the iterative floating-point square-root datapath. It holds the state register and next-state logic in one block, replacing a fixed 51-state linear chain with a configurable step count. It adds a start/busy/done handshake, an abort-with-error path on a negative operand, and an optional stall input. It drives the state index that the controller's output decoder consumes to generate datapath control signals.

## Interface
- NUM_STEPS, 50, number of active states after idle (states 1..NUM_STEPS); legal range 2..(2^STATE_W − 1)
- STATE_W, 6, width of the state index; must satisfy 2^STATE_W > NUM_STEPS
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high; clears all registers on the rising edge of Clk
- start  input  1  request a new operation; sampled only in idle
- negative  input  1  operand sign from the datapath; sampled only in state 1
- hold  input  1  stall; freezes the sequence when high (see Configuration)
- CurrentState  output  STATE_W  registered state index; 0 = idle
- busy  output  1  high whenever CurrentState ≠ 0 (combinational from the state register)
- done  output  1  registered one-cycle pulse on return to idle, after either completion or abort
- error  output  1  registered; set on a negative abort, held until the next accepted start

## Operation
- State 0 (idle): start=1 → state 1 and error cleared; start=0 → remain in 0.
- State 1: negative=1 → state 0 with error=1 and done=1 (abort). Abort has priority over hold. Otherwise state 2, subject to hold.
- States 2..NUM_STEPS−1: advance by 1 per cycle, subject to hold.
- State NUM_STEPS: → state 0 with done=1, subject to hold.
- hold=1 in any state 1..NUM_STEPS (except an abort in state 1): the state is unchanged, and done is not asserted.
- In idle, start is sampled regardless of hold.
- start while busy is ignored and is not queued.
- State values above NUM_STEPS (unreachable): → state 0 next cycle, with done=0 and error unchanged.
- Increment arithmetic is unsigned STATE_W-bit. No wrap is possible because NUM_STEPS < 2^STATE_W.

## Timing
- Reset values: CurrentState=0, busy=0, done=0, error=0.
- Reset mid-operation: on the next edge, all outputs return to their reset values. Any pending done is lost.
- Reset has priority over start, hold and negative.
- Latency with start high in idle at edge k and no hold:
  - CurrentState=1 after edge k.
  - CurrentState=NUM_STEPS after edge k+NUM_STEPS−1.
  - CurrentState=0 and done=1 after edge k+NUM_STEPS.
- Total busy cycles = NUM_STEPS + number of held cycles.
- Abort: in the cycle after state 1 with negative=1, CurrentState=0, done=1 and error=1.
- Back-to-back operation: start=1 in the done cycle is accepted, because the state is idle; the next cycle has CurrentState=1, done=0 and error=0.
- done is never high for two consecutive cycles.

## Configuration
- SQRT_SEQ_HOLD_EN defined: the hold input stalls the sequence as described in Operation.
- SQRT_SEQ_HOLD_EN undefined:
  - The hold port remains present but is ignored.
  - The sequence always advances one state per cycle.
  - Completion latency is exactly NUM_STEPS cycles.

## Test plan
- Nominal run (defaults): Reset for 2 cycles, then start pulse for 1 cycle → CurrentState counts 1..50; on the 51st cycle after start, CurrentState=0 and done=1 for exactly 1 cycle; error=0.
- Negative abort: start, then negative=1 while CurrentState=1 → next cycle CurrentState=0, done=1, error=1. error stays 1 until the next start, then clears on CurrentState=1.
- Hold (macro defined): hold=1 for 3 cycles at CurrentState=20 → state stays 20 for 3 extra cycles; done arrives 53 cycles after start. With the macro undefined, the same stimulus gives done at 50 cycles.
- Back-to-back and ignored start: start held high continuously → done pulses every 51 cycles; start pulses while busy cause no restart.
- Reset mid-run: assert Reset at CurrentState=30 → next cycle CurrentState=0, busy=0, done=0, error=0; no done pulse follows.
- Parameter sweep: NUM_STEPS=2 with STATE_W=2, and NUM_STEPS=255 with STATE_W=8 → done 2 and 255 cycles after start respectively; CurrentState never exceeds NUM_STEPS.

Source files
------------

// File: rtl/sqrt_seq_controller.sv
// State sequencer for the iterative square-root datapath: idle, then steps 1..NUM_STEPS.
// Optional stall input is enabled by defining SQRT_SEQ_HOLD_EN; otherwise hold is ignored.
module sqrt_seq_controller #(
  parameter int NUM_STEPS = 50,
  parameter int STATE_W   = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               negative,
  input  logic               hold,
  output logic [STATE_W-1:0] CurrentState,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [STATE_W-1:0] ONE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STEPS);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_FIRST,
    PH_STEP,
    PH_LAST,
    PH_BAD
  } phase_e;

  logic [STATE_W-1:0] state_q, state_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_eff;
  phase_e             phase;

`ifdef SQRT_SEQ_HOLD_EN
  assign hold_eff = hold;
`else
  logic hold_unused;
  assign hold_unused = hold;
  assign hold_eff    = 1'b0;
`endif

  always_comb begin
    if (state_q == '0)        phase = PH_IDLE;
    else if (state_q > LAST)  phase = PH_BAD;
    else if (state_q == ONE)  phase = PH_FIRST;
    else if (state_q == LAST) phase = PH_LAST;
    else                      phase = PH_STEP;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = error_q;
    case (phase)
      PH_IDLE: begin
        // start is honoured in idle even while hold is asserted
        if (start) begin
          state_d = ONE;
          error_d = 1'b0;
        end
      end
      PH_FIRST: begin
        // a negative operand aborts before hold is considered
        if (negative) begin
          state_d = '0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (!hold_eff) begin
          state_d = state_q + ONE;
        end
      end
      PH_STEP: begin
        if (!hold_eff) state_d = state_q + ONE;
      end
      PH_LAST: begin
        if (!hold_eff) begin
          state_d = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        // unreachable index: fall back to idle quietly
        state_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign CurrentState = state_q;
  assign busy         = (state_q != '0);
  assign done         = done_q;
  assign error        = error_q;

endmodule
